pe_mem_group_reader: RTL and testbench
======================================

// Module: pe_mem_group_reader
// PURPOSE
//  Downstream stage of the PE memory. On a start command it walks
//  dest_pe_index over a PE group (base index + group size, modulo NOF_PES),
//  captures each word returned by the PE memory's combinational read port,
//  and streams the words to the interconnect over a valid/ready interface.
//  It sustains one word per cycle under continuous ready and stalls cleanly
//  on back-pressure.
// PARAMETERS
//  WORD_SIZE         256                 data word width (bits)
//  NOF_PES           16                  number of PEs; power of two, >= 2
//  NOF_LEVELS        $clog2(NOF_PES)     PE index width
//  GROUP_SIZE_WIDTH  NOF_LEVELS+1        group size width; holds 0..NOF_PES
// PORTS
//  clk                  in   1                 clock; all logic on rising edge
//  rst                  in   1                 async reset, active-high
//  start                in   1                 command strobe; sampled in IDLE only
//  base_pe_index        in   NOF_LEVELS        first PE of the group
//  group_size           in   GROUP_SIZE_WIDTH  number of PEs to read
//  busy                 out  1                 high whenever state != IDLE
//  done                 out  1                 one-cycle pulse when a command completes
//  mem_dest_pe_index    out  NOF_LEVELS        read index driven to the PE memory
//  mem_rd_data          in   WORD_SIZE         PE memory output_data (combinational)
//  out_valid            out  1                 out_* holds a valid word
//  out_ready            in   1                 consumer accepts the word
//  out_data             out  WORD_SIZE         word read from the PE memory
//  out_pe_index         out  NOF_LEVELS        PE index the word came from
//  out_last             out  1                 final word of the group
// BEHAVIOUR
//  Clock/reset: one clock clk; reset rst is asynchronous and active-high.
//  Reset values: state=IDLE; busy, done, out_valid, out_last = 0;
//    out_data, out_pe_index, mem_dest_pe_index = 0; internal counters = 0.
//  Reset mid-command: the command is dropped immediately and no done pulse
//    is produced.
//  Registers: cur_idx (NOF_LEVELS) and remaining (GROUP_SIZE_WIDTH).
//    mem_dest_pe_index = cur_idx.
//  The output register loads when load = (state==READ) & (!out_valid | out_ready).
//  FSM:
//   IDLE : If start & group_size!=0: cur_idx<=base_pe_index.
//          remaining<=min(group_size, NOF_PES); go to READ.
//          If start & group_size==0: done=1 on the next cycle; stay in IDLE.
//   READ : On load: out_data<=mem_rd_data, out_pe_index<=cur_idx,
//          out_valid<=1, out_last<=(remaining==1), cur_idx<=cur_idx+1
//          (wraps modulo NOF_PES), remaining<=remaining-1.
//          If load & remaining==1, go to DRAIN.
//   DRAIN: On out_valid & out_ready: out_valid<=0, out_last<=0, done<=1
//          (visible the next cycle), go to IDLE.
//  Handshake: A word transfers on a cycle with out_valid & out_ready.
//    While out_valid & !out_ready, out_data, out_pe_index and out_last are
//    held stable. out_valid never drops without a transfer (except on reset).
//  start is ignored while busy. Command inputs are sampled only on the
//    accepting cycle.
//  Latency: start at cycle 0 -> busy at cycle 1 -> first out_valid at cycle 2.
//    Under continuous out_ready, group size N gives its last transfer at
//    cycle N+1 and done at cycle N+2.
//  Throughput: 1 word/cycle with no bubbles while out_ready=1.
//  group_size > NOF_PES is clamped to NOF_PES; no PE is read twice per command.
//  Wrap-around: base=NOF_PES-2, size=4 reads indices NOF_PES-2, NOF_PES-1, 0, 1.
// TESTING
//  1 Reset: assert rst mid-stream -> all outputs 0 asynchronously; no done
//    after release.
//  2 Basic: mem[i]=i+10, base=3, size=4, ready=1 -> out_data 13,14,15,16 on
//    cycles 2..5; out_last on 16; done on cycle 6.
//  3 Wrap: base=14, size=4 (NOF_PES=16) -> out_pe_index 14,15,0,1; data
//    24,25,10,11.
//  4 Back-pressure: base=0, size=3, ready toggled 1,0,0,1,... -> each word held
//    stable while stalled; order 10,11,12; no loss or duplication.
//  5 Edge sizes: size=0 -> done pulse one cycle after start, out_valid stays 0;
//    size=17 (clamped) -> exactly 16 words.
//  6 Busy: start pulsed again mid-command -> ignored; the first command
//    completes unchanged with a single done pulse.

Source files
------------

// File: rtl/pe_mem_group_reader.sv
// pe_mem_group_reader: walks a PE group through the PE memory read port
// and streams the returned words out over a valid/ready interface.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   start               command strobe, sampled only while idle
//   base_pe_index       first PE of the group
//   group_size          PEs to read (0 = empty command, >NOF_PES clamps)
//   busy                high whenever a command is in flight
//   done                one-cycle pulse when a command completes
//   mem_dest_pe_index   read index into the PE memory
//   mem_rd_data         combinational PE memory read data
//   out_valid/out_ready handshake toward the interconnect
//   out_data            captured memory word
//   out_pe_index        PE the word came from
//   out_last            final word of the group
module pe_mem_group_reader #(
  parameter int WORD_SIZE        = 256,
  parameter int NOF_PES          = 16,
  parameter int NOF_LEVELS       = $clog2(NOF_PES),
  parameter int GROUP_SIZE_WIDTH = NOF_LEVELS + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [NOF_LEVELS-1:0]       base_pe_index,
  input  logic [GROUP_SIZE_WIDTH-1:0] group_size,
  output logic                        busy,
  output logic                        done,
  output logic [NOF_LEVELS-1:0]       mem_dest_pe_index,
  input  logic [WORD_SIZE-1:0]        mem_rd_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_SIZE-1:0]        out_data,
  output logic [NOF_LEVELS-1:0]       out_pe_index,
  output logic                        out_last
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

  localparam logic [GROUP_SIZE_WIDTH-1:0] MAX_SIZE =
    GROUP_SIZE_WIDTH'(NOF_PES);
  localparam logic [GROUP_SIZE_WIDTH-1:0] ONE =
    GROUP_SIZE_WIDTH'(1);
  localparam logic [NOF_LEVELS-1:0] IDX_ONE =
    NOF_LEVELS'(1);

  state_t state;
  state_t state_nxt;

  logic [NOF_LEVELS-1:0]       cur_idx;
  logic [GROUP_SIZE_WIDTH-1:0] remaining;
  logic [GROUP_SIZE_WIDTH-1:0] size_clamped;

  logic accept;
  logic start_run;
  logic start_empty;
  logic load;
  logic last_load;
  logic drain_xfer;

  assign accept      = (state == IDLE) & start;
  assign start_run   = accept & (|group_size);
  assign start_empty = accept & ~(|group_size);

  // Clamping keeps any PE from being read twice in one command.
  assign size_clamped = (group_size > MAX_SIZE) ? MAX_SIZE : group_size;

  // Capture a new word whenever the output slot is empty or being drained
  // this cycle; this gives one word per cycle under continuous ready.
  assign load       = (state == READ) & (~out_valid | out_ready);
  assign last_load  = load & (remaining == ONE);
  assign drain_xfer = (state == DRAIN) & out_valid & out_ready;

  assign busy              = (state != IDLE);
  assign mem_dest_pe_index = cur_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_run) begin
          state_nxt = READ;
        end
      end
      READ: begin
        if (last_load) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (drain_xfer) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_idx      <= '0;
      remaining    <= '0;
      done         <= 1'b0;
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_data     <= '0;
      out_pe_index <= '0;
    end else begin
      done <= start_empty | drain_xfer;

      if (start_run) begin
        cur_idx   <= base_pe_index;
        remaining <= size_clamped;
      end

      // cur_idx is exactly NOF_LEVELS wide, so +1 wraps modulo NOF_PES.
      if (load) begin
        out_data     <= mem_rd_data;
        out_pe_index <= cur_idx;
        out_valid    <= 1'b1;
        out_last     <= (remaining == ONE);
        cur_idx      <= cur_idx + IDX_ONE;
        remaining    <= remaining - ONE;
      end

      if (drain_xfer) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_mem_group_reader.sv
// tb_pe_mem_group_reader: directed and random commands against a
// queue-based model of the group read stream.
module tb_pe_mem_group_reader;

  localparam int W = 256;
  localparam int P = 16;
  localparam int L = 4;
  localparam int G = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [L-1:0] base_pe_index;
  logic [G-1:0] group_size;
  logic         busy;
  logic         done;
  logic [L-1:0] mem_dest_pe_index;
  logic [W-1:0] mem_rd_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [L-1:0] out_pe_index;
  logic         out_last;

  logic [W-1:0] mem [P];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_dest_pe_index];

  pe_mem_group_reader #(
    .WORD_SIZE(W),
    .NOF_PES(P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .base_pe_index(base_pe_index),
    .group_size(group_size),
    .busy(busy),
    .done(done),
    .mem_dest_pe_index(mem_dest_pe_index),
    .mem_rd_data(mem_rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_pe_index(out_pe_index),
    .out_last(out_last)
  );

  task automatic check(input string tag,
                       input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, W'(busy), W'(0));
    check({tag, "_done"}, W'(done), W'(0));
    check({tag, "_valid"}, W'(out_valid), W'(0));
    check({tag, "_last"}, W'(out_last), W'(0));
    check({tag, "_data"}, out_data, W'(0));
    check({tag, "_pe"}, W'(out_pe_index), W'(0));
    check({tag, "_idx"}, W'(mem_dest_pe_index), W'(0));
  endtask

  // mode 0: ready always 1; 1: ready pattern 1,0,0,1; 2: random ready
  task automatic run_cmd(input int b, input int sz,
                         input int mode, input bit restart);
    logic [W-1:0] exp_d [$];
    int           exp_i [$];
    bit           exp_l [$];
    int           n;
    int           cyc;
    int           k;
    bit           seen_done;
    bit           stalled;
    bit           r;
    logic [W-1:0] h_data;
    logic [L-1:0] h_idx;
    logic         h_last;

    n = (sz > P) ? P : sz;
    for (int j = 0; j < n; j++) begin
      exp_i.push_back((b + j) % P);
      exp_d.push_back(mem[(b + j) % P]);
      exp_l.push_back(j == n - 1);
    end

    start         = 1'b1;
    base_pe_index = L'(b);
    group_size    = G'(sz);
    tick();
    start         = 1'b0;
    base_pe_index = L'($urandom);
    group_size    = G'($urandom);
    cyc = 1;

    if (n == 0) begin
      check("empty_done", W'(done), W'(1));
      check("empty_valid", W'(out_valid), W'(0));
      check("empty_busy", W'(busy), W'(0));
      tick();
      check("empty_done_pulse", W'(done), W'(0));
      return;
    end

    check("busy_c1", W'(busy), W'(1));
    k         = 0;
    seen_done = 1'b0;
    stalled   = 1'b0;
    h_data    = '0;
    h_idx     = '0;
    h_last    = 1'b0;

    while (!seen_done && cyc < 300) begin
      if (stalled) begin
        check("hold_data", out_data, h_data);
        check("hold_pe", W'(out_pe_index), W'(h_idx));
        check("hold_last", W'(out_last), W'(h_last));
        check("hold_valid", W'(out_valid), W'(1));
      end
      if (done) begin
        seen_done = 1'b1;
        if (mode == 0) begin
          check("done_cycle", W'(cyc), W'(n + 2));
        end
      end else begin
        case (mode)
          0:       r = 1'b1;
          1:       r = (cyc % 4 == 1) || (cyc % 4 == 0);
          default: r = 1'($urandom_range(0, 1));
        endcase
        out_ready = r;
        start = restart && (cyc == 3);
        if (start) begin
          base_pe_index = L'(7);
          group_size    = G'(2);
        end
        stalled = out_valid && !r;
        if (out_valid && r) begin
          if (exp_d.size() == 0) begin
            check("extra_word", W'(1), W'(exp_d.size()));
          end else begin
            check("data", out_data, exp_d.pop_front());
            check("pe_index", W'(out_pe_index), W'(exp_i.pop_front()));
            check("last", W'(out_last), W'(exp_l.pop_front()));
            if (mode == 0) begin
              check("xfer_cycle", W'(cyc), W'(2 + k));
            end
            k++;
          end
        end
        h_data = out_data;
        h_idx  = out_pe_index;
        h_last = out_last;
        tick();
        cyc++;
      end
    end

    start = 1'b0;
    check("done_seen", W'(seen_done), W'(1));
    check("words_left", W'(exp_d.size()), W'(0));
    tick();
    check("done_pulse", W'(done), W'(0));
    check("idle_busy", W'(busy), W'(0));
    check("idle_valid", W'(out_valid), W'(0));
  endtask

  initial begin
    rst           = 1'b1;
    start         = 1'b0;
    base_pe_index = '0;
    group_size    = '0;
    out_ready     = 1'b0;
    for (int i = 0; i < P; i++) begin
      mem[i] = W'(i + 10);
    end

    #22;
    check_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    tick();

    // basic: 13..16, done on cycle 6
    run_cmd(3, 4, 0, 1'b0);
    // wrap-around
    run_cmd(14, 4, 0, 1'b0);
    // back-pressure
    run_cmd(0, 3, 1, 1'b0);
    // empty command
    run_cmd(9, 0, 0, 1'b0);
    // clamped size: 16 words
    run_cmd(5, 17, 0, 1'b0);
    // start while busy is ignored
    run_cmd(2, 4, 0, 1'b1);

    // reset mid-stream
    start         = 1'b1;
    base_pe_index = L'(0);
    group_size    = G'(8);
    tick();
    start     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    check("pre_rst_valid", W'(out_valid), W'(1));
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("post_rst_done", W'(done), W'(0));
      check("post_rst_valid", W'(out_valid), W'(0));
    end

    // random commands and memory contents
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < P; i++) begin
        logic [W-1:0] v;
        for (int j = 0; j < W / 32; j++) begin
          v[j*32 +: 32] = $urandom;
        end
        mem[i] = v;
      end
      run_cmd($urandom_range(0, P - 1), $urandom_range(0, 20),
              (t % 3 == 0) ? 0 : 2, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
